// File: rtl/mem_pkg.sv
// Shared address-map constants, array sizes and region type for the CPU memory map.
// Optional macro MEM_NROM128_EN selects a 16 KiB PRG ROM (mirrored twice) instead of 32 KiB.
package mem_pkg;

  typedef enum logic [2:0] {
    REGION_RAM      = 3'd0,
    REGION_PPUREG   = 3'd1,
    REGION_IOREG    = 3'd2,
    REGION_UNMAPPED = 3'd3,
    REGION_SRAM     = 3'd4,
    REGION_ROM      = 3'd5
  } region_t;

  // Region base/limit addresses (inclusive limits)
  localparam logic [15:0] RAM_BASE   = 16'h0000;
  localparam logic [15:0] RAM_LIMIT  = 16'h1FFF;
  localparam logic [15:0] PPU_BASE   = 16'h2000;
  localparam logic [15:0] PPU_LIMIT  = 16'h3FFF;
  localparam logic [15:0] IO_BASE    = 16'h4000;
  localparam logic [15:0] IO_LIMIT   = 16'h401F;
  localparam logic [15:0] UNM_BASE   = 16'h4020;
  localparam logic [15:0] UNM_LIMIT  = 16'h5FFF;
  localparam logic [15:0] SRAM_BASE  = 16'h6000;
  localparam logic [15:0] SRAM_LIMIT = 16'h7FFF;
  localparam logic [15:0] ROM_BASE   = 16'h8000;
  localparam logic [15:0] ROM_LIMIT  = 16'hFFFF;

  // Array sizes and index widths
  localparam int RAM_SIZE   = 2048;
  localparam int RAM_AW     = 11;
  localparam int SRAM_SIZE  = 8192;
  localparam int SRAM_AW    = 13;
  localparam int IOREG_SIZE = 40;
  localparam int IOREG_AW   = 6;
  localparam int PPU_REGS   = 8;
`ifdef MEM_NROM128_EN
  localparam int ROM_SIZE   = 16384;
  localparam int ROM_AW     = 14;
`else
  localparam int ROM_SIZE   = 32768;
  localparam int ROM_AW     = 15;
`endif

  // Common index bus wide enough for the largest array
  localparam int IDX_W = 15;

endpackage

// File: rtl/mem_addr_decode.sv
// Combinational CPU address decoder: classifies an address into a region and
// produces the array index inside that region (mirroring folded in).
module mem_addr_decode
  import mem_pkg::*;
(
  input  logic [15:0]      addr,
  output region_t          region,
  output logic [IDX_W-1:0] index
);

  always_comb begin
    region = REGION_UNMAPPED;
    index  = '0;
    if (addr <= RAM_LIMIT) begin
      region = REGION_RAM;
      index  = IDX_W'(addr[RAM_AW-1:0]);
    end else if (addr <= PPU_LIMIT) begin
      // PPU registers repeat every 8 bytes and occupy the low ioreg slots
      region = REGION_PPUREG;
      index  = IDX_W'(addr[2:0]);
    end else if (addr <= IO_LIMIT) begin
      region = REGION_IOREG;
      index  = IDX_W'(PPU_REGS) + IDX_W'(addr[4:0]);
    end else if (addr <= UNM_LIMIT) begin
      region = REGION_UNMAPPED;
      index  = '0;
    end else if (addr <= SRAM_LIMIT) begin
      region = REGION_SRAM;
      index  = IDX_W'(addr[SRAM_AW-1:0]);
    end else begin
      // With a 16 KiB ROM the dropped addr[14] mirrors $8000 onto $C000
      region = REGION_ROM;
      index  = IDX_W'(addr[ROM_AW-1:0]);
    end
  end

endmodule

// File: rtl/mem_top.sv
// CPU-side memory system: RAM, PPU/APU register file, SRAM and PRG ROM behind one
// byte bus with a registered read port. MEM_NROM128_EN selects the 16 KiB ROM build.
module mem_top
  import mem_pkg::*;
#(
  parameter string ROM_INIT_FILE  = "rom.hex",
  parameter string SRAM_INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr_i,
  input  logic [7:0]  data_i,
  input  logic        rw_i,
  output logic [7:0]  data_o
);

  // Bus: rw_i=1 reads addr_i and returns the byte on data_o after the next rising
  // edge; rw_i=0 writes data_i at that edge and leaves data_o untouched.

  logic [7:0] mem_rom_r   [ROM_SIZE];
  logic [7:0] mem_ram_r   [RAM_SIZE];
  logic [7:0] mem_sram_r  [SRAM_SIZE];
  logic [7:0] mem_ioreg_r [IOREG_SIZE];

  region_t          region;
  logic [IDX_W-1:0] index;
  logic [7:0]       rd_byte;
  logic             wr_en;

  mem_addr_decode u_decode (
    .addr   (addr_i),
    .region (region),
    .index  (index)
  );

  assign wr_en = ~rw_i;

  // RAM and SRAM carry no reset so their contents survive rst_n
  always_ff @(posedge clk) begin
    if (wr_en && (region == REGION_RAM)) begin
      mem_ram_r[index[RAM_AW-1:0]] <= data_i;
    end
    if (wr_en && (region == REGION_SRAM)) begin
      mem_sram_r[index[SRAM_AW-1:0]] <= data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < IOREG_SIZE; i++) begin
        mem_ioreg_r[i] <= 8'h00;
      end
    end else if (wr_en && ((region == REGION_PPUREG) || (region == REGION_IOREG))) begin
      mem_ioreg_r[index[IOREG_AW-1:0]] <= data_i;
    end
  end

  always_comb begin
    rd_byte = 8'h00;
    case (region)
      REGION_RAM:    rd_byte = mem_ram_r[index[RAM_AW-1:0]];
      REGION_PPUREG: rd_byte = mem_ioreg_r[index[IOREG_AW-1:0]];
      REGION_IOREG:  rd_byte = mem_ioreg_r[index[IOREG_AW-1:0]];
      REGION_SRAM:   rd_byte = mem_sram_r[index[SRAM_AW-1:0]];
      REGION_ROM:    rd_byte = mem_rom_r[index[ROM_AW-1:0]];
      default:       rd_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_o <= 8'h00;
    end else if (rw_i) begin
      data_o <= rd_byte;
    end
  end

endmodule

// File: tb/tb_mem_top.sv
// Bench for mem_top: directed memory-map scenarios followed by randomized bus
// traffic checked against an address-arithmetic model of the memory map.
module tb_mem_top;
  import mem_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [15:0] addr_i;
  logic [7:0]  data_i;
  logic        rw_i;
  logic [7:0]  data_o;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] last_exp;

  // Reference model state
  logic [7:0] rom_m  [ROM_SIZE];
  logic [7:0] ram_m  [2048];
  logic [7:0] sram_m [8192];
  logic [7:0] io_m   [40];
  bit         ram_known  [2048];
  bit         sram_known [8192];

  logic [7:0] obs_a;
  logic [7:0] obs_b;

  mem_top #(
    .ROM_INIT_FILE  (""),
    .SRAM_INIT_FILE ("")
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .addr_i (addr_i),
    .data_i (data_i),
    .rw_i   (rw_i),
    .data_o (data_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] model_rd(input logic [15:0] a);
    int ai;
    ai = int'(a);
    if (ai < 'h2000) return ram_m[ai % 2048];
    else if (ai < 'h4000) return io_m[ai % 8];
    else if (ai < 'h4020) return io_m[8 + (ai - 'h4000)];
    else if (ai < 'h6000) return 8'h00;
    else if (ai < 'h8000) return sram_m[ai - 'h6000];
    else return rom_m[(ai - 'h8000) % ROM_SIZE];
  endfunction

  task automatic model_wr(input logic [15:0] a, input logic [7:0] d);
    int ai;
    ai = int'(a);
    if (ai < 'h2000) begin
      ram_m[ai % 2048] = d;
      ram_known[ai % 2048] = 1'b1;
    end else if (ai < 'h4000) begin
      io_m[ai % 8] = d;
    end else if (ai < 'h4020) begin
      io_m[8 + (ai - 'h4000)] = d;
    end else if ((ai >= 'h6000) && (ai < 'h8000)) begin
      sram_m[ai - 'h6000] = d;
      sram_known[ai - 'h6000] = 1'b1;
    end
  endtask

  function automatic bit model_known(input logic [15:0] a);
    int ai;
    ai = int'(a);
    if (ai < 'h2000) return ram_known[ai % 2048];
    if ((ai >= 'h6000) && (ai < 'h8000)) return sram_known[ai - 'h6000];
    return 1'b1;
  endfunction

  // Scoreboard comparison
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, want);
    end
  endtask

  // Driver: one bus cycle, checked one edge later
  task automatic bus_op(input logic rw, input logic [15:0] a, input logic [7:0] d,
                        input string tag);
    @(negedge clk);
    rw_i   = rw;
    addr_i = a;
    data_i = d;
    if (rw) begin
      exp_q.push_back(model_rd(a));
    end else begin
      exp_q.push_back(last_exp);
      model_wr(a, d);
    end
    last_exp = exp_q[$];
    @(posedge clk);
    #1;
    check(tag, data_o, exp_q.pop_front());
  endtask

  // Reset asserted mid-cycle while an ioreg write is being driven
  task automatic pulse_reset(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    rw_i   = 1'b0;
    addr_i = a;
    data_i = d;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_dout", data_o, 8'h00);
    for (int i = 0; i < 40; i++) begin
      check($sformatf("rst_io%0d", i), dut.mem_ioreg_r[i], 8'h00);
      io_m[i] = 8'h00;
    end
    last_exp = 8'h00;
    @(posedge clk);
    #1;
    check("rst_hold_io", dut.mem_ioreg_r[30], 8'h00);
    check("rst_hold_dout", data_o, 8'h00);
    @(negedge clk);
    rw_i   = 1'b1;
    addr_i = UNM_BASE;
    rst_n  = 1'b1;
  endtask

  initial begin
    logic [15:0] a;
    logic        rw;
    int          sel;

    rst_n  = 1'b0;
    rw_i   = 1'b1;
    addr_i = UNM_BASE;
    data_i = 8'h00;
    last_exp = 8'h00;
    for (int i = 0; i < 40; i++) io_m[i] = 8'h00;
    for (int i = 0; i < 2048; i++) begin
      ram_m[i] = 8'h00;
      ram_known[i] = 1'b0;
    end
    for (int i = 0; i < 8192; i++) begin
      sram_m[i] = 8'h00;
      sram_known[i] = 1'b0;
    end
    for (int i = 0; i < ROM_SIZE; i++) begin
      rom_m[i] = 8'($urandom);
      dut.mem_rom_r[i] = rom_m[i];
    end
    rom_m[0] = 8'($urandom_range(0, 8'hFE));
    dut.mem_rom_r[0] = rom_m[0];

    #1;
    check("reset_dout", data_o, 8'h00);
    for (int i = 0; i < 40; i += 13) begin
      check($sformatf("reset_io%0d", i), dut.mem_ioreg_r[i], 8'h00);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // RAM mirrors
    bus_op(1'b0, 16'h0002, 8'hA5, "w0002");
    bus_op(1'b1, 16'h0802, 8'h00, "r0802");
    check("r0802_const", data_o, 8'hA5);
    bus_op(1'b1, 16'h1802, 8'h00, "r1802");
    check("r1802_const", data_o, 8'hA5);

    // PPU register mirror
    bus_op(1'b0, 16'h2001, 8'h3C, "w2001");
    check("w2001_hold", data_o, 8'hA5);
    bus_op(1'b1, 16'h3FF9, 8'h00, "r3ff9");
    check("r3ff9_const", data_o, 8'h3C);
    check("ioreg1", dut.mem_ioreg_r[1], 8'h3C);

    // IO register then reset
    bus_op(1'b0, 16'h4016, 8'h77, "w4016");
    check("ioreg30_set", dut.mem_ioreg_r[30], 8'h77);
    pulse_reset(16'h4016, 8'h55);
    check("ioreg30_rst", dut.mem_ioreg_r[30], 8'h00);
    bus_op(1'b1, 16'h0002, 8'h00, "r0002_kept");
    check("r0002_kept_const", data_o, 8'hA5);

    // ROM is read-only
    bus_op(1'b0, 16'h8000, 8'hFF, "w8000");
    bus_op(1'b1, 16'h8000, 8'h00, "r8000");

    // Reset vector
    bus_op(1'b1, 16'hFFFC, 8'h00, "rfffc");
    obs_a = data_o;
    bus_op(1'b1, 16'hFFFD, 8'h00, "rfffd");
`ifdef MEM_NROM128_EN
    bus_op(1'b1, 16'hBFFC, 8'h00, "rbffc");
    obs_b = data_o;
    check("rom_mirror", obs_b, obs_a);
`endif

    // SRAM and unmapped
    bus_op(1'b0, 16'h6000, 8'h12, "w6000");
    bus_op(1'b1, 16'h6000, 8'h00, "r6000");
    check("r6000_const", data_o, 8'h12);
    bus_op(1'b0, 16'h5000, 8'h99, "w5000");
    bus_op(1'b1, 16'h5000, 8'h00, "r5000");
    check("r5000_const", data_o, 8'h00);

    // Randomized traffic across all regions
    for (int n = 0; n < 600; n++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0:       a = 16'($urandom_range(16'h0000, 16'h1FFF));
        1:       a = 16'($urandom_range(16'h2000, 16'h3FFF));
        2:       a = 16'($urandom_range(16'h4000, 16'h401F));
        3:       a = 16'($urandom_range(16'h4020, 16'h5FFF));
        4:       a = 16'($urandom_range(16'h6000, 16'h7FFF));
        default: a = 16'($urandom_range(16'h8000, 16'hFFFF));
      endcase
      rw = 1'($urandom_range(0, 1));
      if (rw && !model_known(a)) rw = 1'b0;
      bus_op(rw, a, 8'($urandom), rw ? "rand_rd" : "rand_wr");
      if ((n % 150) == 149) pulse_reset(16'($urandom_range(16'h4000, 16'h401F)), 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
